uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command controller that sequences the UART block's receive and transmit FIFOs to act as a register-bus master. It pops framed command packets from the receive FIFO, issues single read or write transactions on a simple req/ack register bus, and pushes response bytes into the transmit FIFO. It sits between the UART block and the on-chip register file; it is the only requester of both UART FIFOs.

Parameters:
RX_TIMEOUT, 32'd100000, clk_main cycles allowed between bytes inside a packet before the packet is aborted
BUS_TIMEOUT, 16'd255, clk_main cycles allowed from bus_req rise to bus_ack before the transaction is aborted

Ports:
clk_main  in  1  system clock; single clock domain
rst_n  in  1  asynchronous active-low reset
uart_rf_empty  in  1  UART receive FIFO empty
uart_rd_data  in  8  UART receive data; valid only in a cycle where uart_rd_stb=1 and uart_rf_empty=0
uart_rd_stb  out  1  pop one byte from the receive FIFO
uart_tf_full  in  1  UART transmit FIFO full
uart_wr_stb  out  1  push uart_wr_data into the transmit FIFO
uart_wr_data  out  8  transmit byte
bus_req  out  1  register-bus request; held until ack or timeout
bus_we  out  1  1=write, 0=read; stable while bus_req=1
bus_addr  out  16  register address; stable while bus_req=1
bus_wdata  out  8  write data; stable while bus_req=1
bus_ack  in  1  single-cycle completion from the register bus
bus_rdata  in  8  read data; valid in the bus_ack cycle
busy  out  1  1 when state is not IDLE
err_cnt  out  8  saturating error counter

Behaviour:
- Packet format: write is 0x57, addr_hi, addr_lo, data. Read is 0x52, addr_hi, addr_lo.
- Responses: write success sends 0x06. Read success sends 0x06 followed by the data byte. Any failure sends 0x15.
- States: IDLE, GET_AH, GET_AL, GET_D, BUS, TX_ACK, TX_DATA, TX_NAK.
- Reset (async, rst_n=0):
  - state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - err_cnt=0, timers=0, busy=0.
  - uart_rd_stb and uart_wr_stb are forced 0 while rst_n=0. uart_wr_data=0.
- Receive handshake:
  - uart_rd_stb = (state in IDLE, GET_AH, GET_AL, GET_D) AND !uart_rf_empty. This is combinational.
  - The byte is captured on the same clock edge. At most one byte is popped per cycle.
- Transmit handshake:
  - uart_wr_stb = (state in TX_ACK, TX_DATA, TX_NAK) AND !uart_tf_full. This is combinational.
  - uart_wr_data is decoded from the state: 0x06, captured read data, or 0x15.
  - A byte counts as sent on the edge where uart_wr_stb=1.
- Transitions:
  - IDLE:
    - Byte 0x57 sets the write flag and goes to GET_AH.
    - Byte 0x52 clears the write flag and goes to GET_AH.
    - Any other byte goes to TX_NAK and increments err_cnt.
  - GET_AH: the byte goes to bus_addr[15:8]; next state GET_AL.
  - GET_AL: the byte goes to bus_addr[7:0]; next state is GET_D for a write, BUS for a read.
  - GET_D: the byte goes to bus_wdata; next state BUS.
  - BUS:
    - bus_req=1 and bus_we=write flag, both registered. bus_req rises on the first cycle in BUS.
    - On bus_ack: bus_req drops the next cycle. A read captures bus_rdata. Next state TX_ACK.
  - TX_ACK: after the byte is sent, go to TX_DATA for a read, IDLE for a write.
  - TX_DATA: after the byte is sent, go to IDLE.
  - TX_NAK: after the byte is sent, go to IDLE.
- RX timeout:
  - In GET_AH, GET_AL and GET_D, an idle counter increments each cycle in which no byte is popped. It clears on each pop and on state entry.
  - When the counter reaches RX_TIMEOUT: go to IDLE, err_cnt++, no response, bus_addr and bus_wdata retained. A partial packet is discarded.
- Bus timeout:
  - The counter clears on entry to BUS.
  - If bus_ack has not arrived when the counter reaches BUS_TIMEOUT: bus_req drops the next cycle, go to TX_NAK, err_cnt++.
  - bus_ack in the same cycle the timeout is reached: ack wins.
  - bus_ack outside BUS is ignored.
- err_cnt saturates at 0xFF. Simultaneous error sources cannot occur because only one state is active.
- Latency:
  - Final packet byte popped at edge N gives bus_req=1 after edge N.
  - bus_ack at edge M gives uart_wr_stb possible in cycle M+1.
- Full or empty FIFOs only stall the controller; no byte is lost or duplicated.
- Reset mid-packet or mid-transaction aborts immediately to IDLE with no response. The UART FIFOs are not flushed by this block.

Test Plan:
- Write: rx 57 12 34 A5, ack after 3 cycles -> bus_req with we=1, addr=0x1234, wdata=0xA5, held 3 cycles; tx exactly 06; busy returns 0.
- Read: rx 52 00 10, bus_rdata=0x3C with ack -> we=0, addr=0x0010; tx 06 then 3C; err_cnt=0.
- Bad opcode and back-pressure: rx 41 with uart_tf_full=1 for 10 cycles -> no push while full, then a single 15; err_cnt=1; the next valid packet is processed normally.
- RX timeout (RX_TIMEOUT=20): rx 57 12 then silence -> after 20 idle cycles busy=0, no tx, err_cnt=1, no bus_req.
- Bus timeout (BUS_TIMEOUT=8): rx 52 00 01, no ack -> bus_req high 8 cycles then low; tx 15; err_cnt=1. A repeat with ack exactly on cycle 8 -> tx 06 plus data.
- Async reset asserted in BUS with bus_req=1 -> bus_req=0, busy=0, strobes 0 immediately. After release, packet 57 00 00 FF completes normally; err_cnt saturation check: 260 bad opcodes -> err_cnt=0xFF.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Register-bus link between the UART command controller and the register file.
//   bus_req   : request, held until ack or timeout (master -> slave)
//   bus_we    : 1=write, 0=read, stable while bus_req=1
//   bus_addr  : 16-bit register address, stable while bus_req=1
//   bus_wdata : write data, stable while bus_req=1
//   bus_ack   : single-cycle completion (slave -> master)
//   bus_rdata : read data, valid in the bus_ack cycle
interface uart_cmd_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: pops framed read/write packets from the UART
// receive FIFO, runs one register-bus transaction each and pushes the
// response bytes (0x06 [+ data] or 0x15) into the UART transmit FIFO.
//   clk_main, rst_n : clock, async active-low reset
//   uart_rf_empty, uart_rd_data, uart_rd_stb : receive FIFO pop side
//   uart_tf_full, uart_wr_stb, uart_wr_data  : transmit FIFO push side
//   rbus    : register-bus master (req/we/addr/wdata out, ack/rdata in)
//   busy    : controller not in IDLE
//   err_cnt : saturating count of bad opcodes and timeouts
module uart_cmd_ctrl #(
  parameter logic [31:0] RX_TIMEOUT  = 32'd100000,
  parameter logic [15:0] BUS_TIMEOUT = 16'd255
) (
  input  logic                   clk_main,
  input  logic                   rst_n,
  input  logic                   uart_rf_empty,
  input  logic [7:0]             uart_rd_data,
  output logic                   uart_rd_stb,
  input  logic                   uart_tf_full,
  output logic                   uart_wr_stb,
  output logic [7:0]             uart_wr_data,
  uart_cmd_ctrl_if.master        rbus,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned RXCW  = 32;
  localparam int unsigned BUSCW = 16;

  localparam logic [DW-1:0] OP_WR   = 8'h57;
  localparam logic [DW-1:0] OP_RD   = 8'h52;
  localparam logic [DW-1:0] RSP_ACK = 8'h06;
  localparam logic [DW-1:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE, GET_AH, GET_AL, GET_D, BUS, TX_ACK, TX_DATA, TX_NAK
  } state_t;

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [RXCW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [BUSCW-1:0]  bus_cnt_q, bus_cnt_d;
  logic [DW-1:0]     err_cnt_d;
  logic              err_inc;
  logic              req_d, we_d;
  logic [AW-1:0]     addr_d;
  logic [DW-1:0]     wdata_d;
  logic              rx_pop, tx_push;

  // State register and all registered datapath / outputs
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      is_wr_q        <= 1'b0;
      rdata_q        <= '0;
      rx_cnt_q       <= '0;
      bus_cnt_q      <= '0;
      err_cnt        <= '0;
      busy           <= 1'b0;
      rbus.bus_req   <= 1'b0;
      rbus.bus_we    <= 1'b0;
      rbus.bus_addr  <= '0;
      rbus.bus_wdata <= '0;
    end else begin
      state_q        <= state_d;
      is_wr_q        <= is_wr_d;
      rdata_q        <= rdata_d;
      rx_cnt_q       <= rx_cnt_d;
      bus_cnt_q      <= bus_cnt_d;
      err_cnt        <= err_cnt_d;
      busy           <= (state_d != IDLE);
      rbus.bus_req   <= req_d;
      rbus.bus_we    <= we_d;
      rbus.bus_addr  <= addr_d;
      rbus.bus_wdata <= wdata_d;
    end
  end

  // Next-state, datapath next values and FIFO strobes
  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    rdata_d      = rdata_q;
    rx_cnt_d     = rx_cnt_q;
    bus_cnt_d    = bus_cnt_q;
    err_inc      = 1'b0;
    req_d        = rbus.bus_req;
    we_d         = rbus.bus_we;
    addr_d       = rbus.bus_addr;
    wdata_d      = rbus.bus_wdata;
    rx_pop       = 1'b0;
    tx_push      = 1'b0;
    uart_wr_data = '0;

    unique case (state_q)
      IDLE, GET_AH, GET_AL, GET_D: rx_pop = !uart_rf_empty;
      TX_ACK, TX_DATA, TX_NAK:     tx_push = !uart_tf_full;
      default: ;
    endcase

    unique case (state_q)
      TX_ACK:  uart_wr_data = RSP_ACK;
      TX_DATA: uart_wr_data = rdata_q;
      TX_NAK:  uart_wr_data = RSP_NAK;
      default: uart_wr_data = '0;
    endcase

    // Inside a packet, a cycle without a pop ages the inter-byte timer.
    if ((state_q == GET_AH || state_q == GET_AL || state_q == GET_D) && !rx_pop) begin
      if (rx_cnt_q == RX_TIMEOUT - 32'd1) begin
        state_d = IDLE;
        err_inc = 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + RXCW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rx_pop) begin
          rx_cnt_d = '0;
          if (uart_rd_data == OP_WR) begin
            is_wr_d = 1'b1;
            state_d = GET_AH;
          end else if (uart_rd_data == OP_RD) begin
            is_wr_d = 1'b0;
            state_d = GET_AH;
          end else begin
            state_d = TX_NAK;
            err_inc = 1'b1;
          end
        end
      end
      GET_AH: begin
        if (rx_pop) begin
          addr_d[15:8] = uart_rd_data;
          rx_cnt_d     = '0;
          state_d      = GET_AL;
        end
      end
      GET_AL: begin
        if (rx_pop) begin
          addr_d[7:0] = uart_rd_data;
          rx_cnt_d    = '0;
          if (is_wr_q) begin
            state_d = GET_D;
          end else begin
            state_d   = BUS;
            req_d     = 1'b1;
            we_d      = 1'b0;
            bus_cnt_d = '0;
          end
        end
      end
      GET_D: begin
        if (rx_pop) begin
          wdata_d   = uart_rd_data;
          state_d   = BUS;
          req_d     = 1'b1;
          we_d      = is_wr_q;
          bus_cnt_d = '0;
        end
      end
      BUS: begin
        // Ack in the timeout cycle still counts as success.
        if (rbus.bus_ack) begin
          req_d   = 1'b0;
          state_d = TX_ACK;
          if (!is_wr_q) rdata_d = rbus.bus_rdata;
        end else if (bus_cnt_q == BUS_TIMEOUT - 16'd1) begin
          req_d   = 1'b0;
          state_d = TX_NAK;
          err_inc = 1'b1;
        end else begin
          bus_cnt_d = bus_cnt_q + BUSCW'(1);
        end
      end
      TX_ACK:  if (tx_push) state_d = is_wr_q ? IDLE : TX_DATA;
      TX_DATA: if (tx_push) state_d = IDLE;
      TX_NAK:  if (tx_push) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    err_cnt_d = (err_inc && err_cnt != 8'hFF) ? err_cnt + DW'(1) : err_cnt;
  end

  // Strobes are held off for the whole reset pulse.
  assign uart_rd_stb = rst_n && rx_pop;
  assign uart_wr_stb = rst_n && tx_push;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: models the UART FIFOs and a
// register-bus slave, with scoreboards of expected bus transactions and
// expected transmit bytes.
module tb_uart_cmd_ctrl;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        chk_wd;
    int          ack_at;   // req cycle in which ack is driven, 0 = never
    int          hold;     // expected req-high cycles, 0 = not checked
    logic [7:0]  rdata;
  } txn_t;

  logic       clk_main;
  logic       rst_n;
  logic       uart_rf_empty;
  logic [7:0] uart_rd_data;
  logic       uart_rd_stb;
  logic       uart_tf_full;
  logic       uart_wr_stb;
  logic [7:0] uart_wr_data;
  logic       busy;
  logic [7:0] err_cnt;

  uart_cmd_ctrl_if bus_if ();

  uart_cmd_ctrl #(
    .RX_TIMEOUT  (32'd20),
    .BUS_TIMEOUT (16'd8)
  ) dut (
    .clk_main      (clk_main),
    .rst_n         (rst_n),
    .uart_rf_empty (uart_rf_empty),
    .uart_rd_data  (uart_rd_data),
    .uart_rd_stb   (uart_rd_stb),
    .uart_tf_full  (uart_tf_full),
    .uart_wr_stb   (uart_wr_stb),
    .uart_wr_data  (uart_wr_data),
    .rbus          (bus_if),
    .busy          (busy),
    .err_cnt       (err_cnt)
  );

  int total = 0;
  int bad   = 0;

  int cyc      = 0;
  int last_pop = 0;
  int ack_cyc  = -1;
  int last_chk = -1;
  int req_cycles = 0;

  logic [7:0] rx_mem [1024];
  logic [9:0] rx_wp = '0;
  logic [9:0] rx_rp = '0;

  logic [7:0] tx_exp[$];
  txn_t       bus_exp[$];
  txn_t       cur;

  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Receive FIFO model
  assign uart_rf_empty = (rx_rp == rx_wp);
  assign uart_rd_data  = rx_mem[rx_rp];

  task automatic send(input logic [7:0] b);
    rx_mem[rx_wp] = b;
    rx_wp = rx_wp + 10'd1;
  endtask

  // Cycle counter, RX pops and TX scoreboard
  always @(posedge clk_main) begin
    cyc <= cyc + 1;
    if (uart_rd_stb) begin
      rx_rp    <= rx_rp + 10'd1;
      last_pop <= cyc + 1;
    end
    if (uart_wr_stb) begin
      check("push_while_full", {31'd0, uart_tf_full}, 32'd0);
      if (tx_exp.size() == 0) check("tx_unexpected", 32'(tx_exp.size()), 32'd1);
      else check("tx_byte", {24'd0, uart_wr_data}, {24'd0, tx_exp.pop_front()});
      if (ack_cyc != last_chk) begin
        check("ack_to_tx_lat", 32'(cyc + 1 - ack_cyc), 32'd1);
        last_chk = ack_cyc;
      end
    end
  end

  // Register-bus slave and bus scoreboard, sampled on the falling edge
  always @(negedge clk_main) begin
    if (bus_if.bus_req) begin
      if (req_cycles == 0) begin
        if (bus_exp.size() == 0) begin
          check("bus_unexpected", 32'(bus_exp.size()), 32'd1);
          cur = '{1'b0, 16'h0, 8'h0, 1'b0, 1, 0, 8'h0};
        end else begin
          cur = bus_exp.pop_front();
          check("req_lat", 32'(cyc - last_pop), 32'd0);
        end
      end
      check("bus_we", {31'd0, bus_if.bus_we}, {31'd0, cur.we});
      check("bus_addr", {16'd0, bus_if.bus_addr}, {16'd0, cur.addr});
      if (cur.chk_wd) check("bus_wdata", {24'd0, bus_if.bus_wdata}, {24'd0, cur.wdata});
      req_cycles++;
      bus_if.bus_ack   = (req_cycles == cur.ack_at);
      bus_if.bus_rdata = cur.rdata;
      if (bus_if.bus_ack) ack_cyc = cyc + 1;
    end else begin
      if (req_cycles != 0 && cur.hold != 0) check("req_hold", 32'(req_cycles), 32'(cur.hold));
      req_cycles       = 0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 8'h00;
    end
  end

  task automatic wait_done(input string tag, input int budget);
    int  n = 0;
    bit  done = 0;
    while (!done && n < budget) begin
      @(negedge clk_main);
      n++;
      done = (rx_rp == rx_wp) && !busy && tx_exp.size() == 0 && bus_exp.size() == 0;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_main);
    rst_n = 1'b0;
    @(negedge clk_main);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] b;
    rst_n = 1'b0;
    uart_tf_full = 1'b0;
    repeat (3) @(negedge clk_main);
    check("rst_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {24'd0, err_cnt}, 32'd0);
    check("rst_addr", {16'd0, bus_if.bus_addr}, 32'd0);
    check("rst_wr_data", {24'd0, uart_wr_data}, 32'd0);
    rst_n = 1'b1;

    // Write with ack in the third request cycle
    @(negedge clk_main);
    bus_exp.push_back('{1'b1, 16'h1234, 8'hA5, 1'b1, 3, 3, 8'h00});
    tx_exp.push_back(8'h06);
    send(8'h57); send(8'h12); send(8'h34); send(8'hA5);
    wait_done("write_done", 60);
    check("write_busy", {31'd0, busy}, 32'd0);

    // Read returning 0x3C
    bus_exp.push_back('{1'b0, 16'h0010, 8'h00, 1'b0, 1, 1, 8'h3C});
    tx_exp.push_back(8'h06); tx_exp.push_back(8'h3C);
    send(8'h52); send(8'h00); send(8'h10);
    wait_done("read_done", 60);
    check("read_err", {24'd0, err_cnt}, 32'd0);

    // Bad opcode under transmit back-pressure
    uart_tf_full = 1'b1;
    tx_exp.push_back(8'h15);
    send(8'h41);
    repeat (10) @(negedge clk_main);
    check("nak_held", 32'(tx_exp.size()), 32'd1);
    check("nak_busy", {31'd0, busy}, 32'd1);
    uart_tf_full = 1'b0;
    wait_done("nak_done", 20);
    check("nak_err", {24'd0, err_cnt}, 32'd1);
    bus_exp.push_back('{1'b1, 16'hABCD, 8'h5A, 1'b1, 2, 2, 8'h00});
    tx_exp.push_back(8'h06);
    send(8'h57); send(8'hAB); send(8'hCD); send(8'h5A);
    wait_done("after_nak_done", 60);
    check("after_nak_err", {24'd0, err_cnt}, 32'd1);

    // Receive timeout after a partial packet
    do_reset();
    send(8'h57); send(8'h12);
    n = 0;
    while ((rx_rp != rx_wp || busy) && n < 100) begin
      @(negedge clk_main);
      n++;
    end
    check("rxto_bounded", {31'd0, n < 100}, 32'd1);
    check("rxto_lat", 32'(cyc - last_pop), 32'd20);
    check("rxto_err", {24'd0, err_cnt}, 32'd1);
    check("rxto_addr", {16'd0, bus_if.bus_addr}, 32'h1200);
    repeat (5) @(negedge clk_main);

    // Bus timeout, then ack exactly in the last allowed cycle
    do_reset();
    bus_exp.push_back('{1'b0, 16'h0001, 8'h00, 1'b0, 0, 8, 8'h00});
    tx_exp.push_back(8'h15);
    send(8'h52); send(8'h00); send(8'h01);
    wait_done("busto_done", 60);
    check("busto_err", {24'd0, err_cnt}, 32'd1);
    bus_exp.push_back('{1'b0, 16'h0001, 8'h00, 1'b0, 8, 8, 8'h77});
    tx_exp.push_back(8'h06); tx_exp.push_back(8'h77);
    send(8'h52); send(8'h00); send(8'h01);
    wait_done("bus_late_ack_done", 60);
    check("bus_late_ack_err", {24'd0, err_cnt}, 32'd1);

    // Async reset while a request is outstanding
    do_reset();
    bus_exp.push_back('{1'b1, 16'h0000, 8'hFF, 1'b1, 0, 0, 8'h00});
    send(8'h57); send(8'h00); send(8'h00); send(8'hFF);
    n = 0;
    while (!bus_if.bus_req && n < 30) begin
      @(negedge clk_main);
      n++;
    end
    check("arst_req_seen", {31'd0, bus_if.bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_wr_stb", {31'd0, uart_wr_stb}, 32'd0);
    @(negedge clk_main);
    bus_exp.push_back('{1'b1, 16'h0000, 8'hFF, 1'b1, 2, 2, 8'h00});
    tx_exp.push_back(8'h06);
    send(8'h57); send(8'h00); send(8'h00); send(8'hFF);
    repeat (2) @(negedge clk_main);
    check("arst_rd_stb", {31'd0, uart_rd_stb}, 32'd0);
    rst_n = 1'b1;
    wait_done("arst_after_done", 60);
    check("arst_after_err", {24'd0, err_cnt}, 32'd0);

    // Error counter saturation with random back-pressure
    for (int i = 0; i < 260; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h57 || b == 8'h52) b = 8'h00;
      send(b);
      tx_exp.push_back(8'h15);
    end
    n = 0;
    while (!((rx_rp == rx_wp) && !busy && tx_exp.size() == 0) && n < 3000) begin
      @(negedge clk_main);
      uart_tf_full = ($urandom_range(0, 3) == 0);
      n++;
    end
    uart_tf_full = 1'b0;
    check("sat_done", {31'd0, n < 3000}, 32'd1);
    check("sat_err", {24'd0, err_cnt}, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
